// File: rtl/robot_pkg.sv
// Shared definitions for the robot instruction store: save path and player.
package robot_pkg;

    localparam int INSTR_W = 4;

    typedef enum logic [1:0] {
        FWD   = 2'b00,
        REV   = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic [1:0] torque;
        dir_t       dir;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        RUN,
        FINISH
    } play_state_t;

endpackage

// File: rtl/step_timer.sv
// Per-step hold timer: counts 0..T-1 and flags the read-ahead and last cycles.
module step_timer #(
    parameter int T = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic prefetch,
    output logic terminal
);
    localparam int TW = (T > 2) ? $clog2(T) : 1;

    logic [TW-1:0] timer;
    logic [TW:0]   nxt;

    // Next timer value; one extra bit keeps the +1 free of overflow.
    always_comb begin
        nxt = {1'b0, timer};
        if (clr)
            nxt = '0;
        else if (en)
            nxt = {1'b0, timer} + 1'b1;
    end

    // Timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else
            timer <= nxt[TW-1:0];
    end

    // prefetch looks one cycle ahead: a read strobe registered on it is
    // visible while the timer sits at T-2, so the store answers by T-1.
    assign prefetch = (nxt == (TW+1)'(T - 2));
    assign terminal = (timer == TW'(T - 1));

endmodule

// File: rtl/instr_player.sv
// Plays stored instructions onto the motor outputs, one step per TICKS_PER_STEP clocks.
module instr_player
    import robot_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TICKS_PER_STEP = 50_000_000
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic              motor_en,
    output logic [1:0]        motor_dir,
    output logic [1:0]        motor_torque,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);
    play_state_t       state, state_d;
    logic [ADDR_W:0]   cnt, cnt_d;
    logic              en_d, rd_en_d;
    logic [1:0]        dir_d, torq_d;
    logic [ADDR_W-1:0] idx_d, addr_d;
    logic [ADDR_W:0]   next_idx;
    logic              tmr_clr, tmr_en, tmr_pf, tmr_term;
    instr_t            word;

    assign word = instr_t'(rd_data);

    step_timer #(.T(TICKS_PER_STEP)) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .prefetch (tmr_pf),
        .terminal (tmr_term)
    );

    // Next state, timer control and next motor/step values.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        en_d    = motor_en;
        dir_d   = motor_dir;
        torq_d  = motor_torque;
        idx_d   = step_idx;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (count == '0) begin
                        state_d = FINISH;
                    end else begin
                        cnt_d   = count;
                        state_d = PRIME;
                    end
                end
            end
            PRIME: state_d = LOAD;
            LOAD: begin
                en_d    = 1'b1;
                dir_d   = word.dir;
                torq_d  = word.torque;
                idx_d   = '0;
                tmr_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (tmr_term) begin
                    tmr_clr = 1'b1;
                    if ({1'b0, step_idx} + 1'b1 < cnt) begin
                        dir_d  = word.dir;
                        torq_d = word.torque;
                        idx_d  = step_idx + 1'b1;
                    end else begin
                        en_d    = 1'b0;
                        dir_d   = '0;
                        torq_d  = '0;
                        state_d = FINISH;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            en_d    = 1'b0;
            dir_d   = '0;
            torq_d  = '0;
            idx_d   = '0;
            tmr_clr = 1'b1;
        end
    end

    // Store read strobe: first word on start, then one read-ahead per step.
    always_comb begin
        rd_en_d  = 1'b0;
        addr_d   = (abort && state != IDLE) ? '0 : rd_addr;
        next_idx = {1'b0, idx_d} + 1'b1;
        if (state == IDLE && state_d == PRIME) begin
            rd_en_d = 1'b1;
            addr_d  = '0;
        end else if (state_d == RUN && tmr_pf && next_idx < cnt_d) begin
            rd_en_d = 1'b1;
            addr_d  = next_idx[ADDR_W-1:0];
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            motor_en     <= 1'b0;
            motor_dir    <= '0;
            motor_torque <= '0;
            step_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rd_en        <= rd_en_d;
            rd_addr      <= addr_d;
            motor_en     <= en_d;
            motor_dir    <= dir_d;
            motor_torque <= torq_d;
            step_idx     <= idx_d;
            busy         <= (state_d != IDLE);
            done         <= (state_d == FINISH);
        end
    end

endmodule
